mult_slot_scheduler: RTL and testbench
======================================

// Module: mult_slot_scheduler
// PURPOSE
//  Time-shares one sequential signed multiplier among three products per audio sample (pilot*Kp,
//  RIGHT*sin38, sum*Kf) of the 192 kHz FM stereo path. On each enableclk sample strobe it runs
//  slots 0,1,2 in order: muxes operands, pulses start, waits on ready, latches the product.
//  Replaces free-running phase counters that fire multiplier starts at fixed cycle offsets.
// PARAMETERS
//  A_NBITS   20  multiplier operand A width (signed, all slots sign-extended to this)
//  B_NBITS   9   multiplier operand B width (signed)
//  R_NBITS   29  product width = A_NBITS+B_NBITS
//  TIMEOUT   64  max cycles waiting for mul_ready before a slot aborts (>=2)
// PORTS
//  clock       in   1        system clock
//  reset       in   1        synchronous, active-high
//  enableclk   in   1        sample strobe, 1-cycle pulse, starts a frame
//  slot_en     in   3        per-slot enable; sampled at frame start
//  opa0..opa2  in   A_NBITS  operand A per slot (signed)
//  opb0..opb2  in   B_NBITS  operand B per slot (signed)
//  mul_a       out  A_NBITS  operand A to shared multiplier
//  mul_b       out  B_NBITS  operand B to shared multiplier
//  mul_start   out  1        1-cycle start pulse to multiplier
//  mul_ready   in   1        multiplier done (level)
//  mul_r       in   R_NBITS  multiplier product
//  res0..res2  out  R_NBITS  registered product per slot
//  busy        out  1        high from frame accept until frame_done
//  frame_done  out  1        1-cycle pulse after last slot resolved
//  err_overrun out  1        sticky: enableclk arrived while busy
//  err_timeout out  1        sticky: a slot hit TIMEOUT
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0 (res*, mul_a/b, flags included); reset mid-frame aborts at once,
//   mul_start low next cycle, no frame_done.
//  FSM: IDLE -> SETUP -> START -> ARM -> WAIT -> CAPT -> (next slot SETUP | DONE) -> IDLE.
//  IDLE: enableclk=1 -> latch slot_en, slot=0, busy=1, go SETUP (or DONE if slot_en==0).
//  SETUP: register mul_a/mul_b from opa/opb[slot] this cycle (operands sampled here, so slot k
//   may depend combinationally on res of slots <k). Disabled slot: res[slot]<=0, skip to next.
//  START: mul_start=1 exactly one cycle; mul_a/mul_b held stable until CAPT.
//  ARM: one cycle, mul_ready ignored (covers stale ready from previous op).
//  WAIT: counter from 0; mul_ready=1 -> CAPT. Counter reaching TIMEOUT-1 without ready ->
//   res[slot]<=0, err_timeout<=1, go to next slot.
//  CAPT: res[slot]<=mul_r (full width, no truncation); slot+1; after slot 2 -> DONE.
//  DONE: frame_done=1 one cycle, busy<=0, -> IDLE. busy low in the DONE cycle's successor.
//  Latency: enabled slot with multiplier latency L (start to ready) costs L+4 cycles incl.
//   SETUP/START/ARM/CAPT; full frame = sum + 2 (accept + DONE).
//  enableclk while busy (incl. DONE cycle): ignored, err_overrun<=1; frame in flight unaffected.
//  enableclk and reset same cycle: reset wins.
//  Flags clear only on reset. res* hold value between frames; only updated in own slot.
//  Slot order fixed 0,1,2; no reordering, no pipelining of slots.
// TESTING
//  1 Reset then enableclk, all slots on, opa={100,-3,-131072}, opb={5,-100,255}, model L=9:
//    res={500,300,-33423360}, frame_done exactly once at 2+3*13=41 cycles after strobe.
//  2 slot_en=3'b010: res0,res2 forced 0, exactly one mul_start, frame_done after 15 cycles.
//  3 slot_en=0: no mul_start, frame_done on 2nd cycle after strobe, busy high one cycle.
//  4 Multiplier never raises ready on slot 1, TIMEOUT=64: res1=0, err_timeout=1, slot 2
//    still computed correctly, frame_done asserted.
//  5 Second enableclk 10 cycles into frame: err_overrun=1, only one frame_done, results intact.
//  6 Reset asserted during WAIT of slot 1: next cycle all outputs 0, busy=0; new strobe runs
//    a clean full frame; ready left high from before reset does not cut ARM/WAIT short.

Source files
------------

// File: rtl/mult_slot_scheduler_if.sv
// Shared multiplier bus: operands and start go out from the scheduler,
// ready and product come back from the sequential multiplier.
interface mult_slot_scheduler_if #(
  parameter int A_NBITS = 20,
  parameter int B_NBITS = 9,
  parameter int R_NBITS = A_NBITS + B_NBITS
);
  logic signed [A_NBITS-1:0] mul_a;
  logic signed [B_NBITS-1:0] mul_b;
  logic                      mul_start;
  logic                      mul_ready;
  logic signed [R_NBITS-1:0] mul_r;

  modport master (
    output mul_a,
    output mul_b,
    output mul_start,
    input  mul_ready,
    input  mul_r
  );

  modport slave (
    input  mul_a,
    input  mul_b,
    input  mul_start,
    output mul_ready,
    output mul_r
  );
endinterface

// File: rtl/mult_slot_scheduler.sv
// Time-shares one sequential signed multiplier among three products per
// audio sample. Each sample strobe runs the enabled slots in fixed order
// 0,1,2: operands are muxed and registered, start is pulsed, ready is
// awaited (with a timeout), and the full-width product is latched.
module mult_slot_scheduler #(
  parameter int A_NBITS = 20,
  parameter int B_NBITS = 9,
  parameter int R_NBITS = A_NBITS + B_NBITS,
  parameter int TIMEOUT = 64
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enableclk,
  input  logic [2:0]                i_slot_en,
  input  logic signed [A_NBITS-1:0] i_opa0,
  input  logic signed [A_NBITS-1:0] i_opa1,
  input  logic signed [A_NBITS-1:0] i_opa2,
  input  logic signed [B_NBITS-1:0] i_opb0,
  input  logic signed [B_NBITS-1:0] i_opb1,
  input  logic signed [B_NBITS-1:0] i_opb2,
  mult_slot_scheduler_if.master     mul,
  output logic signed [R_NBITS-1:0] o_res0,
  output logic signed [R_NBITS-1:0] o_res1,
  output logic signed [R_NBITS-1:0] o_res2,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_err_overrun,
  output logic                      o_err_timeout
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_ARM   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_CAPT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // Slot index 3 means "no further enabled slot in this frame".
  localparam logic [1:0] NO_SLOT = 2'd3;

  logic [2:0]                r_state;
  logic [1:0]                r_slot;
  logic [2:0]                r_slot_en;
  logic [CW-1:0]             r_wcnt;
  logic signed [A_NBITS-1:0] r_mul_a;
  logic signed [B_NBITS-1:0] r_mul_b;
  logic signed [R_NBITS-1:0] r_res [3];
  logic                      r_busy;
  logic                      r_err_overrun;
  logic                      r_err_timeout;

  logic signed [A_NBITS-1:0] w_opa;
  logic signed [B_NBITS-1:0] w_opb;
  logic [1:0]                w_from;
  logic [2:0]                w_en;
  logic [1:0]                w_next;
  logic                      w_wait_expired;

  // Lowest enabled slot at or above 'from'; disabled slots are skipped
  // without spending any cycles on them.
  function automatic logic [1:0] next_slot(input logic [2:0] en,
                                           input logic [1:0] from);
    logic [1:0] r;
    r = NO_SLOT;
    for (int k = 2; k >= 0; k--) begin
      if ((2'(k) >= from) && en[k]) r = 2'(k);
    end
    return r;
  endfunction

  // Operand mux and next-slot lookup; the lookup serves both frame accept
  // (search from slot 0 using the live enables) and slot completion.
  always_comb begin
    w_opa = i_opa2;
    w_opb = i_opb2;
    case (r_slot)
      2'd0: begin w_opa = i_opa0; w_opb = i_opb0; end
      2'd1: begin w_opa = i_opa1; w_opb = i_opb1; end
      default: begin w_opa = i_opa2; w_opb = i_opb2; end
    endcase
    w_from = (r_state == S_IDLE) ? 2'd0 : (r_slot + 2'd1);
    w_en   = (r_state == S_IDLE) ? i_slot_en : r_slot_en;
    w_next = next_slot(w_en, w_from);
    w_wait_expired = (r_wcnt == CW'(TIMEOUT - 1));
  end

  // Frame sequencer: slot walk, operand registers, results and sticky flags.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_slot        <= 2'd0;
      r_slot_en     <= 3'd0;
      r_wcnt        <= '0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_res[0]      <= '0;
      r_res[1]      <= '0;
      r_res[2]      <= '0;
      r_busy        <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      // A strobe arriving in any non-idle state (DONE included) is dropped.
      if (i_enableclk && (r_state != S_IDLE)) r_err_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_enableclk) begin
            r_slot_en <= i_slot_en;
            r_busy    <= 1'b1;
            r_slot    <= w_next;
            for (int k = 0; k < 3; k++) begin
              if ((2'(k) >= w_from) && (2'(k) < w_next)) r_res[k] <= '0;
            end
            r_state <= (w_next == NO_SLOT) ? S_DONE : S_SETUP;
          end
        end

        S_SETUP: begin
          // Sampled here so a later slot can use results of earlier slots.
          r_mul_a <= w_opa;
          r_mul_b <= w_opb;
          r_state <= S_START;
        end

        S_START: begin
          r_state <= S_ARM;
        end

        // ARM gives the multiplier a cycle to drop a ready left over from
        // the previous operation before ready is trusted.
        S_ARM: begin
          r_wcnt  <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (mul.mul_ready) begin
            r_state <= S_CAPT;
          end else if (w_wait_expired) begin
            r_res[r_slot] <= '0;
            r_err_timeout <= 1'b1;
            r_slot        <= w_next;
            for (int k = 0; k < 3; k++) begin
              if ((2'(k) >= w_from) && (2'(k) < w_next)) r_res[k] <= '0;
            end
            r_state <= (w_next == NO_SLOT) ? S_DONE : S_SETUP;
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
          end
        end

        S_CAPT: begin
          r_res[r_slot] <= mul.mul_r;
          r_slot        <= w_next;
          for (int k = 0; k < 3; k++) begin
            if ((2'(k) >= w_from) && (2'(k) < w_next)) r_res[k] <= '0;
          end
          r_state <= (w_next == NO_SLOT) ? S_DONE : S_SETUP;
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mul.mul_a     = r_mul_a;
  assign mul.mul_b     = r_mul_b;
  assign mul.mul_start = (r_state == S_START);

  assign o_res0        = r_res[0];
  assign o_res1        = r_res[1];
  assign o_res2        = r_res[2];
  assign o_busy        = r_busy;
  assign o_frame_done  = (r_state == S_DONE);
  assign o_err_overrun = r_err_overrun;
  assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_mult_slot_scheduler.sv
// Directed bench for mult_slot_scheduler: a latency-9 multiplier model with
// a one-cycle stale ready after each start, a table of frame vectors, and
// hand-written reset sequences.
module tb_mult_slot_scheduler;
  localparam int A  = 20;
  localparam int B  = 9;
  localparam int R  = 29;
  localparam int TO = 64;
  localparam int L  = 9;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [2:0] slot_en;
  logic signed [A-1:0] opa0, opa1, opa2;
  logic signed [B-1:0] opb0, opb1, opb2;
  logic signed [R-1:0] res0, res1, res2;
  logic busy, frame_done, err_ov, err_to;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_slot_scheduler_if #(.A_NBITS(A), .B_NBITS(B), .R_NBITS(R)) mif ();

  mult_slot_scheduler #(.A_NBITS(A), .B_NBITS(B), .R_NBITS(R), .TIMEOUT(TO)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_enableclk  (en),
    .i_slot_en    (slot_en),
    .i_opa0       (opa0),
    .i_opa1       (opa1),
    .i_opa2       (opa2),
    .i_opb0       (opb0),
    .i_opb1       (opb1),
    .i_opb2       (opb2),
    .mul          (mif.master),
    .o_res0       (res0),
    .o_res1       (res1),
    .o_res2       (res2),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_err_overrun(err_ov),
    .o_err_timeout(err_to)
  );

  // Multiplier model: ready rises L+1 cycles after the start cycle and stays
  // high until the next start; the old ready lingers one cycle past a start.
  logic signed [R-1:0] m_prod = '0;
  logic signed [R-1:0] m_r    = '0;
  int   m_cnt    = 0;
  logic m_run    = 1'b0;
  logic m_done   = 1'b0;
  logic m_hold   = 1'b0;
  logic m_dead   = 1'b0;
  int   m_starts = 0;
  int   mute_abs = -1;
  int   done_cnt = 0;

  assign mif.mul_ready = m_done | m_hold;
  assign mif.mul_r     = m_r;

  always @(posedge clk) begin
    m_hold <= 1'b0;
    if (mif.mul_start === 1'b1) begin
      m_hold   <= m_done | m_hold;
      m_cnt    <= L;
      m_prod   <= mif.mul_a * mif.mul_b;
      m_run    <= 1'b1;
      m_dead   <= (m_starts == mute_abs);
      m_starts <= m_starts + 1;
      m_done   <= 1'b0;
    end else if (m_run) begin
      if (m_cnt > 1) m_cnt <= m_cnt - 1;
      else begin
        m_run <= 1'b0;
        if (!m_dead) begin
          m_done <= 1'b1;
          m_r    <= m_prod;
        end
      end
    end
  end

  always @(posedge clk) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [2:0] en;
    int opa0, opa1, opa2, opb0, opb1, opb2;
    int mute, ovr;
    int r0, r1, r2;
    int done_at, starts;
    bit to, ov;
  } vec_t;

  vec_t vt[5];
  vec_t vpost;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    slot_en = v.en;
    opa0 = A'(v.opa0); opa1 = A'(v.opa1); opa2 = A'(v.opa2);
    opb0 = B'(v.opb0); opb1 = B'(v.opb1); opb2 = B'(v.opb2);
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    int d0, s0, cyc, busy_n, done_at;
    bit found;
    load(v);
    mute_abs = (v.mute >= 0) ? (m_starts + v.mute) : -1;
    d0 = done_cnt;
    s0 = m_starts;
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    found = 1'b0; cyc = 1; busy_n = 0; done_at = -1;
    while (!found && cyc <= 300) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (frame_done === 1'b1) begin found = 1'b1; done_at = cyc; end
      @(posedge clk); #1;
      cyc++;
      en = (cyc == v.ovr);
    end
    en = 1'b0;
    @(negedge clk);
    chk({nm, " done_cycle"}, done_at, v.done_at);
    chk({nm, " busy_cycles"}, busy_n, v.done_at);
    chk({nm, " busy_after"}, busy, 0);
    chk({nm, " res0"}, res0, v.r0);
    chk({nm, " res1"}, res1, v.r1);
    chk({nm, " res2"}, res2, v.r2);
    chk({nm, " starts"}, m_starts - s0, v.starts);
    chk({nm, " done_pulses"}, done_cnt - d0, 1);
    chk({nm, " err_timeout"}, err_to, v.to);
    chk({nm, " err_overrun"}, err_ov, v.ov);
    mute_abs = -1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " res0"}, res0, 0);
    chk({nm, " res1"}, res1, 0);
    chk({nm, " res2"}, res2, 0);
    chk({nm, " mul_a"}, mif.mul_a, 0);
    chk({nm, " mul_b"}, mif.mul_b, 0);
    chk({nm, " mul_start"}, mif.mul_start, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " frame_done"}, frame_done, 0);
    chk({nm, " err_overrun"}, err_ov, 0);
    chk({nm, " err_timeout"}, err_to, 0);
  endtask

  initial begin
    int d0;
    vt[0] = '{3'b111, 100, -3, -131072, 5, -100, 255, -1, 0,
              500, 300, -33423360, 40, 3, 1'b0, 1'b0};
    vt[1] = '{3'b010, 1000, -2000, 3000, 1, 2, 3, -1, 0,
              0, -4000, 0, 14, 1, 1'b0, 1'b0};
    vt[2] = '{3'b000, 1, 2, 3, 4, 5, 6, -1, 0,
              0, 0, 0, 1, 0, 1'b0, 1'b0};
    vt[3] = '{3'b111, -524288, 524287, 0, -256, -256, 17, -1, 10,
              134217728, -134217472, 0, 40, 3, 1'b0, 1'b1};
    vt[4] = '{3'b111, 7, 11, -13, -2, 3, 4, 1, 0,
              -14, 0, -52, 94, 3, 1'b1, 1'b1};
    vpost = '{3'b111, 12, -34, 56, -7, 8, -9, -1, 0,
              -84, -272, -504, 40, 3, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b0; slot_en = 3'b000;
    opa0 = '0; opa1 = '0; opa2 = '0; opb0 = '0; opb1 = '0; opb2 = '0;
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("reset_wins busy", busy, 0);
    chk("reset_wins frame_done", frame_done, 0);

    for (int i = 0; i < 5; i++) run_frame(vt[i], $sformatf("vec%0d", i));

    // Abort a frame in the WAIT of slot 1, then run a clean frame while the
    // multiplier still holds ready from the aborted operation.
    load(vt[0]);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk_zero("midreset");
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("midreset no_done", done_cnt - d0, 0);
    chk("midreset stale_ready", mif.mul_ready, 1);
    run_frame(vpost, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
